// File: rtl/regfile_writeback_queue_if.sv
// Bundle of request, register-file write port and bypass lookup signals
// shared between the writeback queue and whatever drives/consumes it.
interface regfile_writeback_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             InValid;
  logic             InReady;
  logic [4:0]       InRegister;
  logic [WIDTH-1:0] InData;
  logic             DrainEnable;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [4:0]       LookupRegister1;
  logic             Hit1;
  logic [WIDTH-1:0] HitData1;
  logic [4:0]       LookupRegister2;
  logic             Hit2;
  logic [WIDTH-1:0] HitData2;
  logic [CNT_W-1:0] Count;

  modport master (
    output InValid, InRegister, InData, DrainEnable,
           LookupRegister1, LookupRegister2,
    input  InReady, WriteRegister, WriteData, RegWrite,
           Hit1, HitData1, Hit2, HitData2, Count
  );

  modport slave (
    input  InValid, InRegister, InData, DrainEnable,
           LookupRegister1, LookupRegister2,
    output InReady, WriteRegister, WriteData, RegWrite,
           Hit1, HitData1, Hit2, HitData2, Count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order write buffer in front of the register file write port. Requests are
// queued, drained one per cycle when the write port is free, and pending values
// are exposed through two bypass lookups (youngest matching entry wins).
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic                      Clk,
  input logic                      Reset,
  regfile_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       reg_q  [DEPTH];
  logic [4:0]       reg_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  logic             occupied;
  logic             full;
  logic             accept;
  logic             store;
  logic             pop;

  logic             hit1, hit2;
  logic [WIDTH-1:0] hit_data1, hit_data2;
  logic [PTR_W-1:0] lookup_idx;

  // Handshake qualifiers depend only on registered occupancy; register 0 is dropped
  always_comb begin
    occupied = (count_q != '0);
    full     = (count_q == CNT_W'(DEPTH));
    accept   = bus.InValid & ~full;
    store    = accept & (bus.InRegister != 5'd0);
    pop      = bus.DrainEnable & occupied;
  end

  // Next-state: store at tail, pop at head, occupancy follows the pair
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    reg_d   = reg_q;
    data_d  = data_q;
    if (store) begin
      reg_d[tail_q]  = bus.InRegister;
      data_d[tail_q] = bus.InData;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (store && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!store && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State register; reset discards every pending entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  // Bypass lookups walk oldest to youngest so the youngest match overrides
  always_comb begin
    hit1       = 1'b0;
    hit2       = 1'b0;
    hit_data1  = '0;
    hit_data2  = '0;
    lookup_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((bus.LookupRegister1 != 5'd0) && (reg_q[lookup_idx] == bus.LookupRegister1)) begin
          hit1      = 1'b1;
          hit_data1 = data_q[lookup_idx];
        end
        if ((bus.LookupRegister2 != 5'd0) && (reg_q[lookup_idx] == bus.LookupRegister2)) begin
          hit2      = 1'b1;
          hit_data2 = data_q[lookup_idx];
        end
      end
    end
  end

  assign bus.InReady       = ~full;
  assign bus.RegWrite      = pop;
  assign bus.WriteRegister = occupied ? reg_q[head_q]  : 5'd0;
  assign bus.WriteData     = occupied ? data_q[head_q] : '0;
  assign bus.Hit1          = hit1;
  assign bus.HitData1      = hit_data1;
  assign bus.Hit2          = hit2;
  assign bus.HitData2      = hit_data2;
  assign bus.Count         = count_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scenario bench for the register-file writeback queue. A negedge monitor keeps
// a queue of expected writes and checks the write port, Count and InReady every
// cycle; each scenario task adds its own targeted checks.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]       r;
    logic [WIDTH-1:0] d;
  } entry_t;

  logic   Clk;
  logic   Reset;
  int     num_checks;
  int     num_errors;
  int     writes_seen;
  entry_t sb[$];

  int     mon_size;
  logic   mon_ready;
  logic   mon_write;
  entry_t mon_head;

  regfile_writeback_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard: compare write port against the oldest expected entry, then update the model
  always @(negedge Clk) begin
    if (Reset) begin
      sb.delete();
    end else begin
      mon_size  = sb.size();
      mon_ready = (mon_size != DEPTH);
      mon_write = bus.DrainEnable && (mon_size != 0);
      num_checks++;
      if (bus.Count !== CNT_W'(mon_size)) begin
        num_errors++;
        $display("[TB] FAIL mon_count actual=%0d required=%0d", bus.Count, mon_size);
      end
      num_checks++;
      if (bus.InReady !== mon_ready) begin
        num_errors++;
        $display("[TB] FAIL mon_in_ready actual=%b required=%b", bus.InReady, mon_ready);
      end
      num_checks++;
      if (bus.RegWrite !== mon_write) begin
        num_errors++;
        $display("[TB] FAIL mon_reg_write actual=%b required=%b", bus.RegWrite, mon_write);
      end
      num_checks++;
      if (mon_size != 0) begin
        mon_head = sb[0];
        if (bus.WriteRegister !== mon_head.r || bus.WriteData !== mon_head.d) begin
          num_errors++;
          $display("[TB] FAIL mon_write_port actual=r%0d/0x%h required=r%0d/0x%h",
                   bus.WriteRegister, bus.WriteData, mon_head.r, mon_head.d);
        end
      end else if (bus.WriteRegister !== 5'd0 || bus.WriteData !== '0) begin
        num_errors++;
        $display("[TB] FAIL mon_idle_port actual=r%0d/0x%h required=r0/0x0",
                 bus.WriteRegister, bus.WriteData);
      end
      if (mon_write) begin
        void'(sb.pop_front());
        writes_seen++;
      end
      if (bus.InValid && mon_ready && bus.InRegister != 5'd0) begin
        sb.push_back('{r: bus.InRegister, d: bus.InData});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    num_checks++;
    if (bus.RegWrite !== 1'b0 || bus.InReady !== 1'b1 || bus.Count !== '0) begin
      num_errors++;
      $display("[TB] FAIL reset_state actual=we%b/rdy%b/cnt%0d required=we0/rdy1/cnt0",
               bus.RegWrite, bus.InReady, bus.Count);
    end
    num_checks++;
    if (bus.Hit1 !== 1'b0 || bus.Hit2 !== 1'b0 || bus.HitData1 !== '0 || bus.HitData2 !== '0) begin
      num_errors++;
      $display("[TB] FAIL reset_hits actual=%b/%b/0x%h/0x%h required=0/0/0/0",
               bus.Hit1, bus.Hit2, bus.HitData1, bus.HitData2);
    end
    num_checks++;
    if (bus.WriteRegister !== 5'd0 || bus.WriteData !== '0) begin
      num_errors++;
      $display("[TB] FAIL reset_port actual=r%0d/0x%h required=r0/0x0", bus.WriteRegister, bus.WriteData);
    end
  endtask

  task automatic test_fill_and_hold();
    logic [4:0]  regs [4];
    logic [31:0] vals [4];
    regs = '{5'd5, 5'd6, 5'd5, 5'd7};
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.DrainEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.InValid    = 1'b1;
      bus.InRegister = regs[i];
      bus.InData     = vals[i];
      tick();
    end
    bus.InRegister      = 5'd8;
    bus.InData          = 32'h88;
    bus.LookupRegister1 = 5'd5;
    bus.LookupRegister2 = 5'd8;
    #1;
    num_checks++;
    if (bus.Count !== CNT_W'(4) || bus.InReady !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL fill_full actual=cnt%0d/rdy%b required=cnt4/rdy0", bus.Count, bus.InReady);
    end
    num_checks++;
    if (bus.Hit1 !== 1'b1 || bus.HitData1 !== 32'h33) begin
      num_errors++;
      $display("[TB] FAIL fill_youngest_hit actual=%b/0x%h required=1/0x33", bus.Hit1, bus.HitData1);
    end
    num_checks++;
    if (bus.Hit2 !== 1'b0 || bus.HitData2 !== '0) begin
      num_errors++;
      $display("[TB] FAIL fill_held_not_hit actual=%b/0x%h required=0/0x0", bus.Hit2, bus.HitData2);
    end
    tick();
    tick();
    num_checks++;
    if (bus.Count !== CNT_W'(4)) begin
      num_errors++;
      $display("[TB] FAIL fill_hold_count actual=%0d required=4", bus.Count);
    end
  endtask

  task automatic test_drain();
    int  start_writes;
    bit  accepted;
    start_writes        = writes_seen;
    bus.DrainEnable     = 1'b1;
    bus.LookupRegister1 = 5'd5;
    bus.LookupRegister2 = 5'd6;
    #1;
    num_checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'h11) begin
      num_errors++;
      $display("[TB] FAIL drain_first actual=%b/r%0d/0x%h required=1/r5/0x11",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    num_checks++;
    if (bus.InReady !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL drain_full_blocks actual=%b required=0", bus.InReady);
    end
    num_checks++;
    if (bus.Hit1 !== 1'b1 || bus.HitData1 !== 32'h33 || bus.Hit2 !== 1'b1 || bus.HitData2 !== 32'h22) begin
      num_errors++;
      $display("[TB] FAIL drain_head_hits actual=%b/0x%h/%b/0x%h required=1/0x33/1/0x22",
               bus.Hit1, bus.HitData1, bus.Hit2, bus.HitData2);
    end
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      tick();
      #1;
      if (bus.InReady === 1'b1) begin
        accepted = 1'b1;
        tick();
        bus.InValid = 1'b0;
      end
    end
    num_checks++;
    if (!accepted) begin
      num_errors++;
      $display("[TB] FAIL drain_r8_accept actual=not_accepted required=accepted");
    end
    for (int k = 0; k < 20 && bus.Count !== '0; k++) tick();
    num_checks++;
    if (bus.Count !== '0 || (writes_seen - start_writes) != 5) begin
      num_errors++;
      $display("[TB] FAIL drain_total actual=cnt%0d/writes%0d required=cnt0/writes5",
               bus.Count, writes_seen - start_writes);
    end
  endtask

  task automatic test_back_to_back();
    int start_writes;
    start_writes    = writes_seen;
    bus.DrainEnable = 1'b0;
    bus.InValid     = 1'b1;
    bus.InRegister  = 5'd1;
    bus.InData      = 32'h100;
    tick();
    bus.InRegister  = 5'd2;
    bus.InData      = 32'h101;
    tick();
    bus.DrainEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.InRegister = 5'((i % 29) + 3);
      bus.InData     = 32'h1000 + i;
      #1;
      num_checks++;
      if (bus.Count !== CNT_W'(2) || bus.RegWrite !== 1'b1) begin
        num_errors++;
        $display("[TB] FAIL b2b_steady[%0d] actual=cnt%0d/we%b required=cnt2/we1", i, bus.Count, bus.RegWrite);
      end
      tick();
    end
    bus.InValid = 1'b0;
    for (int k = 0; k < 10 && bus.Count !== '0; k++) tick();
    num_checks++;
    if (bus.Count !== '0 || (writes_seen - start_writes) != 18) begin
      num_errors++;
      $display("[TB] FAIL b2b_total actual=cnt%0d/writes%0d required=cnt0/writes18",
               bus.Count, writes_seen - start_writes);
    end
  endtask

  task automatic test_reg_zero();
    int start_writes;
    start_writes        = writes_seen;
    bus.DrainEnable     = 1'b0;
    bus.InValid         = 1'b1;
    bus.InRegister      = 5'd0;
    bus.InData          = 32'hDEAD;
    bus.LookupRegister1 = 5'd0;
    #1;
    num_checks++;
    if (bus.InReady !== 1'b1 || bus.Hit1 !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL r0_handshake actual=rdy%b/hit%b required=rdy1/hit0", bus.InReady, bus.Hit1);
    end
    tick();
    bus.InRegister      = 5'd3;
    bus.InData          = 32'h3333;
    bus.LookupRegister1 = 5'd3;
    #1;
    num_checks++;
    if (bus.Count !== '0 || bus.Hit1 !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL r0_dropped_no_bypass actual=cnt%0d/hit%b required=cnt0/hit0", bus.Count, bus.Hit1);
    end
    tick();
    bus.InRegister      = 5'd0;
    bus.InData          = 32'hBEEF;
    bus.LookupRegister2 = 5'd0;
    tick();
    bus.InValid = 1'b0;
    #1;
    num_checks++;
    if (bus.Count !== CNT_W'(1) || bus.Hit1 !== 1'b1 || bus.HitData1 !== 32'h3333 || bus.Hit2 !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL r0_lookup actual=cnt%0d/%b/0x%h/%b required=cnt1/1/0x3333/0",
               bus.Count, bus.Hit1, bus.HitData1, bus.Hit2);
    end
    bus.DrainEnable = 1'b1;
    tick();
    tick();
    num_checks++;
    if (bus.Count !== '0 || bus.RegWrite !== 1'b0 || (writes_seen - start_writes) != 1) begin
      num_errors++;
      $display("[TB] FAIL r0_total actual=cnt%0d/we%b/writes%0d required=cnt0/we0/writes1",
               bus.Count, bus.RegWrite, writes_seen - start_writes);
    end
  endtask

  task automatic test_reset_mid();
    int start_writes;
    bus.DrainEnable = 1'b0;
    bus.InValid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.InRegister = 5'(9 + i);
      bus.InData     = 32'h99 + 32'(i * 17);
      tick();
    end
    bus.InValid         = 1'b0;
    bus.LookupRegister1 = 5'd10;
    #1;
    num_checks++;
    if (bus.Count !== CNT_W'(3) || bus.Hit1 !== 1'b1 || bus.HitData1 !== 32'hAA) begin
      num_errors++;
      $display("[TB] FAIL rst_mid_pending actual=cnt%0d/%b/0x%h required=cnt3/1/0xaa",
               bus.Count, bus.Hit1, bus.HitData1);
    end
    Reset = 1'b1;
    tick();
    Reset           = 1'b0;
    bus.DrainEnable = 1'b1;
    start_writes    = writes_seen;
    #1;
    num_checks++;
    if (bus.Count !== '0 || bus.RegWrite !== 1'b0 || bus.Hit1 !== 1'b0 || bus.HitData1 !== '0) begin
      num_errors++;
      $display("[TB] FAIL rst_mid_cleared actual=cnt%0d/we%b/%b/0x%h required=cnt0/we0/0/0x0",
               bus.Count, bus.RegWrite, bus.Hit1, bus.HitData1);
    end
    repeat (4) tick();
    num_checks++;
    if ((writes_seen - start_writes) != 0 || bus.RegWrite !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL rst_mid_no_writes actual=writes%0d required=writes0", writes_seen - start_writes);
    end
  endtask

  initial begin
    num_checks          = 0;
    num_errors          = 0;
    writes_seen         = 0;
    Reset               = 1'b1;
    bus.InValid         = 1'b0;
    bus.InRegister      = 5'd0;
    bus.InData          = '0;
    bus.DrainEnable     = 1'b0;
    bus.LookupRegister1 = 5'd0;
    bus.LookupRegister2 = 5'd0;
    test_reset();
    test_fill_and_hold();
    test_drain();
    test_back_to_back();
    test_reg_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
